pixel_unpacker: RTL and testbench

Upstream stage of the LED string path. It pops 16-bit words from the first-word-fall-through pixel FIFO and repacks every 3 words into 2 24-bit RGB colors. It presents the colors one at a time on a valid/ack interface to the string wrapper. A 2-entry output buffer decouples FIFO reads from consumer pops. A sync strobe realigns packing at frame boundaries.

---
 rtl/pixel_unpacker.sv | 90 +++++++++
 tb/tb_pixel_unpacker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: pops 16-bit words from a FWFT pixel FIFO and repacks
// each 3-word tuple into 2 x 24-bit {R,G,B} colors. The colors sit in a small
// output buffer and are handed to the consumer over a valid/ack interface.
// A sync strobe realigns packing at frame boundaries.
module pixel_unpacker #(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_rd_en,
  input  logic        sync,
  input  logic        color_ack,
  output logic        color_valid,
  output logic [23:0] color_out,
  output logic        align_err
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);

  typedef enum logic [1:0] {P0, P1, P2} phase_t;

  phase_t          phase;
  logic [15:0]     residual;
  logic [CW-1:0]   count;
  logic [23:0]     ent_q   [OUT_DEPTH];
  logic [23:0]     ent_nxt [OUT_DEPTH];
  logic            push, pop;
  logic [23:0]     push_data;
  logic [CW-1:0]   wr_idx;

  // A P0 read only fills the residual, so it may proceed with a full buffer.
  // The ack of the same cycle is deliberately not credited.
  assign fifo_rd_en  = !reset && !fifo_empty && !sync && (phase == P0 || count < FULL);
  assign push        = fifo_rd_en && (phase != P0);
  assign pop         = color_ack && (count != '0);
  assign color_valid = (count != '0);
  assign color_out   = ent_q[0];

  // Assemble the color produced by a P1 or P2 read.
  always_comb begin
    push_data = {residual[7:0], fifo_data};
    if (phase == P1) push_data = {residual, fifo_data[15:8]};
  end

  // Next buffer contents: shift toward the head on pop, then write at the tail.
  always_comb begin
    wr_idx = pop ? count - CW'(1) : count;
    for (int i = 0; i < OUT_DEPTH; i++) ent_nxt[i] = ent_q[i];
    if (pop) begin
      for (int i = 0; i < OUT_DEPTH - 1; i++) ent_nxt[i] = ent_q[i+1];
    end
    if (push) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        if (wr_idx == CW'(i)) ent_nxt[i] = push_data;
      end
    end
  end

  // Phase FSM, residual, buffer and sticky alignment error.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= P0;
      residual  <= '0;
      count     <= '0;
      align_err <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) ent_q[i] <= '0;
    end else if (sync) begin
      // sync beats a same-cycle ack: the whole buffer is discarded
      phase    <= P0;
      residual <= '0;
      count    <= '0;
      if (phase != P0) align_err <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        case (phase)
          P0:      begin residual <= fifo_data;               phase <= P1; end
          P1:      begin residual <= {8'h00, fifo_data[7:0]}; phase <= P2; end
          default: begin                                      phase <= P0; end
        endcase
      end
      if (push) assert (count < FULL);
      count <= count + CW'(push) - CW'(pop);
      for (int i = 0; i < OUT_DEPTH; i++) ent_q[i] <= ent_nxt[i];
    end
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Bench for pixel_unpacker: directed scenarios followed by random traffic, all
// checked every cycle against a word/color queue model.
module tb_pixel_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data = '0;
  logic        fifo_rd_en;
  logic        sync = 1'b0;
  logic        color_ack = 1'b0;
  logic        color_valid;
  logic [23:0] color_out;
  logic        align_err;

  pixel_unpacker #(.OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .sync(sync), .color_ack(color_ack),
    .color_valid(color_valid), .color_out(color_out), .align_err(align_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] wq[$];    // pixel FIFO contents
  logic [15:0] tup[$];   // words popped in the current tuple
  logic [23:0] eq[$];    // colors the consumer should still see, head first
  logic [23:0] got[$];   // colors actually handed over on ack
  bit          m_err = 0;
  bit          m_zero = 0;
  int          pops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit r, input bit a, input bit s);
    logic        exp_rd, act_rd;
    logic [15:0] w;
    logic [31:0] t32;
    logic [47:0] t48;
    reset = r; color_ack = a; sync = s;
    fifo_empty = (wq.size() == 0);
    fifo_data  = (wq.size() != 0) ? wq[0] : 16'h0;
    #1;
    exp_rd = !r && !fifo_empty && !s && (tup.size() == 0 || eq.size() < 2);
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("valid", color_valid, eq.size() != 0);
    if (eq.size() != 0) chk("color", color_out, eq[0]);
    else if (m_zero) chk("color_after_reset", color_out, 0);
    chk("align_err", align_err, m_err);
    act_rd = fifo_rd_en;
    if (a && color_valid) got.push_back(color_out);
    if (act_rd) pops++;
    w = fifo_data;
    @(posedge clk);
    m_zero = r;
    if (r) begin
      eq.delete(); tup.delete(); m_err = 0;
    end else if (s) begin
      if (tup.size() != 0) m_err = 1;
      eq.delete(); tup.delete();
    end else begin
      if (a && eq.size() != 0) void'(eq.pop_front());
      if (exp_rd) begin
        tup.push_back(w);
        if (tup.size() == 2) begin
          t32 = {tup[0], tup[1]};
          eq.push_back(t32[31:8]);
        end else if (tup.size() == 3) begin
          t48 = {tup[0], tup[1], tup[2]};
          eq.push_back(t48[23:0]);
          tup.delete();
        end
      end
    end
    if (act_rd && wq.size() != 0) void'(wq.pop_front());
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] w9[9];
    logic [23:0] ex[$];
    logic [47:0] t48;
    logic [23:0] c1;

    // Let reset settle, then check reset state with words already waiting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    wq.push_back(16'h1122); wq.push_back(16'h3344); wq.push_back(16'h5566);
    cycle(1, 0, 0);

    // Basic pack
    pops = 0; got.delete();
    repeat (8) cycle(0, 1, 0);
    chk("basic_pops", pops, 3);
    chk("basic_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("basic_c0", got[0], 24'h112233);
      chk("basic_c1", got[1], 24'h445566);
    end

    // Back-pressure: 9 words, consumer silent, then drains everything
    ex.delete();
    for (int i = 0; i < 9; i++) begin
      w9[i] = 16'($urandom);
      wq.push_back(w9[i]);
    end
    for (int t = 0; t < 3; t++) begin
      t48 = {w9[3*t], w9[3*t+1], w9[3*t+2]};
      ex.push_back(t48[47:24]);
      ex.push_back(t48[23:0]);
    end
    pops = 0; got.delete();
    repeat (10) cycle(0, 0, 0);
    chk("bp_pops", pops, 4);
    chk("bp_head", color_out, ex[0]);
    repeat (15) cycle(0, 1, 0);
    chk("bp_n", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("bp_order", got[i], ex[i]);

    // Simultaneous push and ack while one color is buffered
    wq.push_back(16'hA1B2); wq.push_back(16'hC3D4); wq.push_back(16'hE5F6);
    t48 = {16'hA1B2, 16'hC3D4, 16'hE5F6};
    c1 = t48[23:0];
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("pa_valid", color_valid, 1);
    chk("pa_c1", color_out, c1);
    repeat (3) cycle(0, 1, 0);

    // Misaligned sync after one pop
    wq.push_back(16'hDEAD);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("mis_err", align_err, 1);
    chk("mis_valid", color_valid, 0);
    wq.push_back(16'h0102); wq.push_back(16'h0304); wq.push_back(16'h0506);
    got.delete();
    repeat (6) cycle(0, 1, 0);
    chk("mis_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("mis_c0", got[0], 24'h010203);
      chk("mis_c1", got[1], 24'h040506);
    end

    // Aligned sync at P0 with a full buffer
    cycle(1, 0, 0);
    wq.push_back(16'h1111); wq.push_back(16'h2222); wq.push_back(16'h3333);
    repeat (4) cycle(0, 0, 0);
    chk("al_full", color_valid, 1);
    cycle(0, 1, 1);
    chk("al_valid", color_valid, 0);
    chk("al_err", align_err, 0);

    // Reset mid-operation: full buffer, phase P1, one word still waiting
    for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
    repeat (6) cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("rst_valid", color_valid, 0);
    chk("rst_color", color_out, 0);
    wq.delete();
    wq.push_back(16'hCAFE); wq.push_back(16'hBEEF); wq.push_back(16'h1234);
    got.delete();
    repeat (6) cycle(0, 1, 0);
    chk("rst_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("rst_c0", got[0], 24'hCAFEBE);
      chk("rst_c1", got[1], 24'hEF1234);
    end

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) != 0 && wq.size() < 8) wq.push_back(16'($urandom));
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
